// File: rtl/parallel_cmd_responder.sv
// ---------------------------------------------------------------------------
// parallel_cmd_responder
//
// Host-facing parallel command/response engine. The asynchronous host strobe,
// chip-select and data byte are synchronised into iCLK. A command byte selects
// one of NUM_CH sensor channels. The block then freezes a coherent snapshot of
// that channel and returns it as DATA_W/8 bytes, LSB-first or MSB-first.
//
// Optional build macro: PAR_CHECKSUM_EN
//   When defined, one extra checksum byte follows the data bytes. Its value is
//   the XOR of the command byte and every data byte.
//
// Ports:
//   iCLK, iRSTN   system clock, asynchronous active-low reset
//   iRP_CLK       host strobe (async); a rising edge while CS is low = strobe
//   iRP_CS        host chip select, active-low (async)
//   iRP_DATA      byte driven by the host
//   oRP_DATA      byte returned to the host (registered)
//   oRP_OE        drive enable for the oRP_DATA pins
//   iSAMPLE       packed channel samples, channel c at [c*DATA_W +: DATA_W]
//   iSAMPLE_VLD   per-channel sample-valid strobes
//   oCMD_CH       last accepted channel index
//   oBUSY         high while a transfer is in progress
//   oBAD_CMD      one-cycle pulse when a command byte is rejected
//   oTIMEOUT      one-cycle pulse when a transfer is aborted by the idle timer
// ---------------------------------------------------------------------------
module parallel_cmd_responder #(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                          iCLK,
  input  logic                                          iRSTN,
  input  logic                                          iRP_CLK,
  input  logic                                          iRP_CS,
  input  logic [7:0]                                    iRP_DATA,
  output logic [7:0]                                    oRP_DATA,
  output logic                                          oRP_OE,
  input  logic [NUM_CH*DATA_W-1:0]                      iSAMPLE,
  input  logic [NUM_CH-1:0]                             iSAMPLE_VLD,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] oCMD_CH,
  output logic                                          oBUSY,
  output logic                                          oBAD_CMD,
  output logic                                          oTIMEOUT
);

  localparam int NBYTES  = DATA_W / 8;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TO_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN   = (TIMEOUT_CYC > 0);
  localparam int TO_LAST = TO_EN ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_SUM  = 2'd2
  } state_t;

  // Byte k of the transfer, counted in the order the host receives it.
  function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] v,
                                         input int                k,
                                         input logic              msb_first);
    logic [DATA_W-1:0] shifted;
    int                pos;
    pos     = msb_first ? (NBYTES - 1 - k) : k;
    shifted = v >> (8 * pos);
    return shifted[7:0];
  endfunction

`ifdef PAR_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int k = 0; k < NBYTES; k++) acc ^= v[k*8 +: 8];
    return acc;
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Pin synchronisers. Strobe and CS chains reset to the inactive/high level
  // so that a host already holding its clock high at reset release is not
  // mistaken for a rising strobe edge.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   clk_prev;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, which is what makes a shift chain work.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      clk_sync <= '1;
      cs_sync  <= '1;
      clk_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      clk_sync     <= {clk_sync[SYNC_STAGES-2:0], iRP_CLK};
      cs_sync      <= {cs_sync[SYNC_STAGES-2:0], iRP_CS};
      data_sync[0] <= iRP_DATA;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      clk_prev     <= clk_sync[SYNC_STAGES-1];
    end
  end

  logic       cs_high;
  logic       strobe;
  logic [7:0] rx_byte;

  assign cs_high = cs_sync[SYNC_STAGES-1];
  assign strobe  = clk_sync[SYNC_STAGES-1] & ~clk_prev & ~cs_high;
  assign rx_byte = data_sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Per-channel hold registers: always track the latest valid sample.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] hold [NUM_CH];

  // NOTE: the hold array is cleared by reset because its contents are
  // host-visible; a read before the first sample must return zero.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int c = 0; c < NUM_CH; c++) hold[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (iSAMPLE_VLD[c]) hold[c] <= iSAMPLE[c*DATA_W +: DATA_W];
      end
    end
  end

  // Sample for the channel named in rx_byte, bypassing the hold register when
  // a fresh sample lands in the very cycle the command is accepted.
  logic [DATA_W-1:0] sel_sample;
  logic              cmd_valid;

  // NOTE: sel_sample gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rx_byte[4:0]) == c) begin
        sel_sample = iSAMPLE_VLD[c] ? iSAMPLE[c*DATA_W +: DATA_W] : hold[c];
      end
    end
  end

  assign cmd_valid = rx_byte[7] & ~rx_byte[5] & (int'(rx_byte[4:0]) < NUM_CH);

  // -------------------------------------------------------------------------
  // Transfer FSM with registered outputs.
  // -------------------------------------------------------------------------
  state_t            state;
  logic [DATA_W-1:0] snapshot;
  logic [IDX_W-1:0]  byte_idx;
  logic              msb_first;
  logic [TO_W-1:0]   idle_cnt;
  logic              timeout_hit;
`ifdef PAR_CHECKSUM_EN
  logic [7:0]        sum_byte;
`endif

  assign timeout_hit = TO_EN && (int'(idle_cnt) == TO_LAST);

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state     <= S_IDLE;
      snapshot  <= '0;
      byte_idx  <= '0;
      msb_first <= 1'b0;
      idle_cnt  <= '0;
      oRP_DATA  <= '0;
      oRP_OE    <= 1'b0;
      oCMD_CH   <= '0;
      oBUSY     <= 1'b0;
      oBAD_CMD  <= 1'b0;
      oTIMEOUT  <= 1'b0;
`ifdef PAR_CHECKSUM_EN
      sum_byte  <= '0;
`endif
    end else begin
      oBAD_CMD <= 1'b0;
      oTIMEOUT <= 1'b0;
      case (state)
        S_IDLE: begin
          // Bytes without the marker bit are silently ignored.
          if (strobe && rx_byte[7]) begin
            if (cmd_valid) begin
              state     <= S_SEND;
              snapshot  <= sel_sample;
              oCMD_CH   <= rx_byte[CH_W-1:0];
              byte_idx  <= '0;
              msb_first <= rx_byte[6];
              idle_cnt  <= '0;
              oRP_DATA  <= byte_of(sel_sample, 0, rx_byte[6]);
              oRP_OE    <= 1'b1;
              oBUSY     <= 1'b1;
`ifdef PAR_CHECKSUM_EN
              sum_byte  <= rx_byte ^ xor_bytes(sel_sample);
`endif
            end else begin
              oBAD_CMD <= 1'b1;
            end
          end
        end

        S_SEND, S_SUM: begin
          // Priority: CS abort, then strobe, then idle timeout.
          if (cs_high) begin
            state    <= S_IDLE;
            oRP_DATA <= '0;
            oRP_OE   <= 1'b0;
            oBUSY    <= 1'b0;
          end else if (strobe) begin
            idle_cnt <= '0;
            if (state == S_SEND && int'(byte_idx) != NBYTES - 1) begin
              byte_idx <= byte_idx + IDX_W'(1);
              oRP_DATA <= byte_of(snapshot, int'(byte_idx) + 1, msb_first);
            end
`ifdef PAR_CHECKSUM_EN
            else if (state == S_SEND) begin
              state    <= S_SUM;
              oRP_DATA <= sum_byte;
            end
`endif
            else begin
              state    <= S_IDLE;
              oRP_DATA <= '0;
              oRP_OE   <= 1'b0;
              oBUSY    <= 1'b0;
            end
          end else if (timeout_hit) begin
            state    <= S_IDLE;
            oRP_DATA <= '0;
            oRP_OE   <= 1'b0;
            oBUSY    <= 1'b0;
            oTIMEOUT <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          oRP_DATA <= '0;
          oRP_OE   <= 1'b0;
          oBUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_parallel_cmd_responder
//
// Self-checking bench for parallel_cmd_responder (NUM_CH=3, DATA_W=16,
// TIMEOUT_CYC=100, SYNC_STAGES=2). A behavioural model keeps the latest sample
// per channel and derives each transfer's byte list from the command rules.
// Build with PAR_CHECKSUM_EN defined to exercise the checksum byte.
// ---------------------------------------------------------------------------
module tb_parallel_cmd_responder;

  localparam int NUM_CH  = 3;
  localparam int DATA_W  = 16;
  localparam int TO_CYC  = 100;
  localparam int SS      = 2;
  localparam int NB      = DATA_W / 8;

  logic                     clk;
  logic                     rst_n;
  logic                     rp_clk;
  logic                     rp_cs;
  logic [7:0]               rp_din;
  logic [7:0]               rp_dout;
  logic                     rp_oe;
  logic [NUM_CH*DATA_W-1:0] sample;
  logic [NUM_CH-1:0]        sample_vld;
  logic [1:0]               cmd_ch;
  logic                     busy;
  logic                     bad_cmd;
  logic                     timeout;

  parallel_cmd_responder #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC), .SYNC_STAGES(SS)
  ) dut (
    .iCLK(clk), .iRSTN(rst_n), .iRP_CLK(rp_clk), .iRP_CS(rp_cs),
    .iRP_DATA(rp_din), .oRP_DATA(rp_dout), .oRP_OE(rp_oe),
    .iSAMPLE(sample), .iSAMPLE_VLD(sample_vld), .oCMD_CH(cmd_ch),
    .oBUSY(busy), .oBAD_CMD(bad_cmd), .oTIMEOUT(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500 us");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  int seen_bad, seen_oe, seen_to;

  // Reference model state.
  logic [DATA_W-1:0] model_hold [NUM_CH];
  int                model_cmd_ch;
  logic [7:0]        exp_q [$];

  // Advance n cycles, sampling outputs at each falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bad_cmd) seen_bad++;
      if (rp_oe)   seen_oe++;
      if (timeout) seen_to++;
    end
  endtask

  // One host strobe: data set up first, then a clean pulse on rp_clk.
  task automatic host_write(input logic [7:0] b);
    seen_bad = 0; seen_oe = 0; seen_to = 0;
    rp_din = b;
    step(3);
    rp_clk = 1'b1;
    step(5);
    rp_clk = 1'b0;
    step(3);
  endtask

  task automatic pulse_sample(input int ch, input logic [DATA_W-1:0] val);
    sample[ch*DATA_W +: DATA_W] = val;
    sample_vld = NUM_CH'(1) << ch;
    model_hold[ch] = val;
    step(1);
    sample_vld = '0;
  endtask

  // Byte list a valid command must return, built from the command rules.
  task automatic build_expect(input logic [7:0] cmd, input logic [DATA_W-1:0] val);
    logic [7:0] sum;
    exp_q.delete();
    sum = cmd;
    for (int i = 0; i < NB; i++) begin
      if (cmd[6]) exp_q.push_front(val[8*i +: 8]);
      else        exp_q.push_back(val[8*i +: 8]);
      sum ^= val[8*i +: 8];
    end
`ifdef PAR_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  // Full transfer of a valid command; optionally updates a channel's sample
  // right after byte upd_after has been presented.
  task automatic do_transfer(input logic [7:0] cmd, input int upd_after,
                             input int upd_ch, input logic [DATA_W-1:0] upd_val);
    int ch;
    ch = int'(cmd[4:0]);
    build_expect(cmd, model_hold[ch]);
    model_cmd_ch = ch;
    host_write(cmd);
    total++;
    if (cmd_ch !== 2'(model_cmd_ch)) begin
      bad++;
      $display("FAIL xfer_cmd_ch cmd=%h got=%0d exp=%0d", cmd, cmd_ch, model_cmd_ch);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (rp_oe !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL xfer_active cmd=%h byte=%0d oe=%b busy=%b exp oe=1 busy=1", cmd, i, rp_oe, busy);
      end
      total++;
      if (rp_dout !== exp_q[i]) begin
        bad++;
        $display("FAIL xfer_byte cmd=%h byte=%0d got=%h exp=%h", cmd, i, rp_dout, exp_q[i]);
      end
      if (upd_after == i) pulse_sample(upd_ch, upd_val);
      host_write(8'($urandom));
    end
    total++;
    if (rp_oe !== 1'b0 || busy !== 1'b0 || rp_dout !== 8'h00) begin
      bad++;
      $display("FAIL xfer_end cmd=%h oe=%b busy=%b data=%h exp 0/0/00", cmd, rp_oe, busy, rp_dout);
    end
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rp_clk     = 1'($urandom);
      rp_cs      = 1'($urandom);
      rp_din     = 8'($urandom);
      sample     = {$urandom, $urandom};
      sample_vld = 3'($urandom);
    end
    step(1);
    total++;
    if ({rp_dout, rp_oe, cmd_ch, busy, bad_cmd, timeout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs data=%h oe=%b ch=%0d busy=%b bad=%b to=%b exp all 0",
               rp_dout, rp_oe, cmd_ch, busy, bad_cmd, timeout);
    end
    rp_clk = 1'b0; rp_cs = 1'b1; rp_din = 8'h00; sample_vld = '0;
    for (int c = 0; c < NUM_CH; c++) model_hold[c] = '0;
    model_cmd_ch = 0;
    step(3);
    rst_n = 1'b1;
    step(4);
    total++;
    if (rp_oe !== 1'b0 || busy !== 1'b0 || cmd_ch !== 2'd0 || rp_dout !== 8'h00) begin
      bad++;
      $display("FAIL reset_release oe=%b busy=%b ch=%0d data=%h exp 0/0/0/00", rp_oe, busy, cmd_ch, rp_dout);
    end
    rp_cs = 1'b0;
    step(3);
    // Hold registers start cleared: a read before any sample returns zeros.
    do_transfer(8'h80, -1, 0, '0);
  endtask

  task automatic test_read_order();
    pulse_sample(1, 16'hABCD);
    do_transfer(8'h81, -1, 0, '0);
    do_transfer(8'hC1, -1, 0, '0);
    pulse_sample(0, 16'h5A3C);
    do_transfer(8'hC0, -1, 0, '0);
  endtask

  task automatic test_bad_cmd();
    logic [7:0] bytes [3];
    int         exp_bad [3];
    bytes = '{8'h83, 8'hA0, 8'h41};
    exp_bad = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      host_write(bytes[i]);
      total++;
      if (seen_bad != exp_bad[i] || seen_oe != 0) begin
        bad++;
        $display("FAIL bad_cmd byte=%h pulses=%0d oe_cycles=%0d exp pulses=%0d oe_cycles=0",
                 bytes[i], seen_bad, seen_oe, exp_bad[i]);
      end
      total++;
      if (cmd_ch !== 2'(model_cmd_ch)) begin
        bad++;
        $display("FAIL bad_cmd_ch byte=%h got=%0d exp=%0d", bytes[i], cmd_ch, model_cmd_ch);
      end
    end
  endtask

  task automatic test_snapshot();
    pulse_sample(1, 16'hABCD);
    do_transfer(8'h81, 0, 1, 16'h1234);
    do_transfer(8'h81, -1, 0, '0);
  endtask

  // Sample-valid in the same cycle the command is accepted must be bypassed.
  task automatic test_bypass();
    logic [DATA_W-1:0] nv;
    nv = 16'h6E91;
    pulse_sample(2, 16'h0F0F);
    rp_din = 8'h82;
    step(3);
    rp_clk = 1'b1;
    step(SS);
    sample[2*DATA_W +: DATA_W] = nv;
    sample_vld = 3'b100;
    model_hold[2] = nv;
    step(1);
    sample_vld = '0;
    step(2);
    rp_clk = 1'b0;
    step(3);
    model_cmd_ch = 2;
    total++;
    if (rp_dout !== nv[7:0] || rp_oe !== 1'b1) begin
      bad++;
      $display("FAIL bypass_byte0 got=%h oe=%b exp=%h oe=1", rp_dout, rp_oe, nv[7:0]);
    end
    host_write(8'h00);
    total++;
    if (rp_dout !== nv[15:8]) begin
      bad++;
      $display("FAIL bypass_byte1 got=%h exp=%h", rp_dout, nv[15:8]);
    end
    host_write(8'h00);
`ifdef PAR_CHECKSUM_EN
    host_write(8'h00);
`endif
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bypass_end busy=%b exp=0", busy);
    end
  endtask

  task automatic test_timeout();
    int k;
    model_cmd_ch = 0;
    rp_din = 8'h80;
    step(3);
    rp_clk = 1'b1;
    seen_to = 0;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (timeout) begin k = i; break; end
    end
    total++;
    if (k != SS + 1 + TO_CYC) begin
      bad++;
      $display("FAIL timeout_latency got=%0d exp=%0d cycles after pin edge", k, SS + 1 + TO_CYC);
    end
    step(1);
    total++;
    if (timeout !== 1'b0 || busy !== 1'b0 || rp_oe !== 1'b0) begin
      bad++;
      $display("FAIL timeout_after to=%b busy=%b oe=%b exp 0/0/0", timeout, busy, rp_oe);
    end
    rp_clk = 1'b0;
    step(3);
    // A strobe reloads the idle counter: total transfer time exceeds the
    // limit, but no single gap does.
    host_write(8'h80);
    step(60);
    host_write(8'h00);
    step(60);
    total++;
    if (busy !== 1'b1 || seen_to != 0) begin
      bad++;
      $display("FAIL timeout_reload busy=%b pulses=%0d exp busy=1 pulses=0", busy, seen_to);
    end
    host_write(8'h00);
`ifdef PAR_CHECKSUM_EN
    host_write(8'h00);
`endif
  endtask

  task automatic test_cs_abort();
    pulse_sample(0, 16'h4321);
    host_write(8'h80);
    host_write(8'h00);
    total++;
    if (busy !== 1'b1 || rp_dout !== 8'h43) begin
      bad++;
      $display("FAIL cs_pre busy=%b data=%h exp busy=1 data=43", busy, rp_dout);
    end
    seen_to = 0; seen_bad = 0;
    rp_cs = 1'b1;
    step(SS + 2);
    total++;
    if (rp_oe !== 1'b0 || busy !== 1'b0 || rp_dout !== 8'h00 || seen_to != 0 || seen_bad != 0) begin
      bad++;
      $display("FAIL cs_abort oe=%b busy=%b data=%h to=%0d bad=%0d exp 0/0/00/0/0",
               rp_oe, busy, rp_dout, seen_to, seen_bad);
    end
    rp_cs = 1'b0;
    step(3);
  endtask

`ifdef PAR_CHECKSUM_EN
  task automatic test_checksum();
    pulse_sample(1, 16'hABCD);
    host_write(8'h81);
    host_write(8'h00);
    host_write(8'h00);
    total++;
    if (rp_dout !== 8'hE7 || rp_oe !== 1'b1) begin
      bad++;
      $display("FAIL checksum_byte got=%h oe=%b exp=e7 oe=1", rp_dout, rp_oe);
    end
    host_write(8'h00);
    total++;
    if (busy !== 1'b0 || rp_oe !== 1'b0) begin
      bad++;
      $display("FAIL checksum_end busy=%b oe=%b exp 0/0", busy, rp_oe);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  b;
    int          ch;
    logic        expect_bad;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1) == 1) begin
        ch = int'($urandom_range(NUM_CH - 1));
        pulse_sample(ch, DATA_W'($urandom));
      end
      if ($urandom_range(3) != 0)
        b = {1'b1, 1'($urandom), 1'b0, 5'($urandom_range(NUM_CH - 1))};
      else
        b = 8'($urandom);
      ch = int'(b[4:0]);
      if (b[7] && !b[5] && ch < NUM_CH) begin
        do_transfer(b, int'($urandom_range(NB)), int'($urandom_range(NUM_CH - 1)),
                    DATA_W'($urandom));
      end else begin
        expect_bad = b[7];
        host_write(b);
        total++;
        if (seen_bad != int'(expect_bad) || seen_oe != 0) begin
          bad++;
          $display("FAIL rand_reject byte=%h pulses=%0d oe_cycles=%0d exp pulses=%0d oe_cycles=0",
                   b, seen_bad, seen_oe, int'(expect_bad));
        end
      end
    end
  endtask

  initial begin
    rp_clk = 1'b0; rp_cs = 1'b1; rp_din = '0; sample = '0; sample_vld = '0;
    test_reset();
    test_read_order();
    test_bad_cmd();
    test_snapshot();
    test_bypass();
    test_timeout();
    test_cs_abort();
`ifdef PAR_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_cmd_responder.md
Name: parallel_cmd_responder

Overview:
Parametrised successor to the Raspberry Pi parallel command/response logic. It synchronises the host strobe, chip-select and data byte into the system clock and decodes command bytes. It selects one of NUM_CH sensor channels and returns a coherent DATA_W-bit snapshot of that channel as DATA_W/8 bytes, in either byte order. It sits between parallel pin I/O (tristate at top level) and the sensor readout blocks, and drives the channel select to them.

Parameters:
NUM_CH, 3, number of sample channels (1..32)
DATA_W, 16, bits per channel sample; multiple of 8, 8..64
TIMEOUT_CYC, 50000, iCLK cycles without a strobe in a transfer before abort; 0 disables timeout
SYNC_STAGES, 2, flip-flop stages on iRP_CLK, iRP_CS, iRP_DATA (>=2)

Ports:
iCLK  in  1  system clock (50 MHz)
iRSTN  in  1  asynchronous active-low reset
iRP_CLK  in  1  host strobe, asynchronous
iRP_CS  in  1  host chip select, active-low, asynchronous
iRP_DATA  in  8  host-driven byte
oRP_DATA  out  8  byte returned to host
oRP_OE  out  1  pin drive enable for oRP_DATA
iSAMPLE  in  NUM_CH*DATA_W  channel samples; channel c at [c*DATA_W +: DATA_W]
iSAMPLE_VLD  in  NUM_CH  per-channel sample-valid strobe
oCMD_CH  out  max(1,$clog2(NUM_CH))  last accepted channel index
oBUSY  out  1  high while a transfer is in progress
oBAD_CMD  out  1  one-cycle pulse on rejected command
oTIMEOUT  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async assert, sync release): state IDLE; hold regs, snapshot, oRP_DATA, oCMD_CH all 0; oRP_OE, oBUSY, oBAD_CMD, oTIMEOUT low.
- Strobe event: a rising edge of synchronised iRP_CLK while synchronised iRP_CS is low. The byte is taken from synchronised iRP_DATA. Detection occurs SYNC_STAGES+1 cycles after the pin edge.
- Command byte format: bit7=1 marker; bit6 = order (0 = LSB first, 1 = MSB first); bit5 must be 0; bits[4:0] = channel.
- Hold regs: hold[c] <= iSAMPLE slice when iSAMPLE_VLD[c] is high. Updates are never blocked.
- IDLE, valid command (marker=1, bit5=0, chan<NUM_CH):
  - snapshot <= hold[chan], bypassing to the new sample if iSAMPLE_VLD[chan] is in the same cycle;
  - oCMD_CH <= chan; byte index <= 0; go SEND.
  - Next cycle: oRP_DATA = byte 0 in the selected order; oRP_OE=1; oBUSY=1.
- IDLE, invalid command: oBAD_CMD pulses, stay IDLE, oCMD_CH unchanged.
- IDLE, non-command byte (bit7=0): ignored silently.
- SEND:
  - Each strobe consumes the current byte and advances the index. After the strobe that consumes byte DATA_W/8-1, go IDLE: oRP_OE=0, oBUSY=0, oRP_DATA=0x00.
  - Bytes received during SEND are ignored, never decoded.
- Abort, CS: synchronised iRP_CS high in SEND -> IDLE next cycle. No pulse.
- Abort, timeout: an idle counter in SEND reloads on every strobe. When it reaches TIMEOUT_CYC -> IDLE, oTIMEOUT pulses for 1 cycle.
- Simultaneous: timeout and strobe in the same cycle -> the strobe wins. CS abort has priority over both.
- Snapshot is fixed for the whole transfer. iSAMPLE_VLD during SEND only updates hold regs.
- Reset mid-transfer -> immediate IDLE, all outputs at reset values.

Optional Feature:
PAR_CHECKSUM_EN
- Defined: after the last data byte, the block presents one extra byte in a SUM state. Value = XOR of the command byte and all data bytes. The strobe that consumes it returns the block to IDLE. CS and timeout aborts apply in SUM.
- Undefined: no SUM state; the transfer ends after the DATA_W/8 data bytes.

Test Plan:
(NUM_CH=3, DATA_W=16, TIMEOUT_CYC=100, macro undefined unless stated)
1. Reset with all inputs toggling -> all outputs 0, oCMD_CH=0; release -> state IDLE, oRP_OE=0.
2. iSAMPLE_VLD[1] with ch1=0xABCD, then command 0x81 followed by two strobes -> oRP_DATA=0xCD then 0xAB; oCMD_CH=1; IDLE after the 2nd strobe. Command 0xC1 -> 0xAB then 0xCD.
3. Command 0x83 (chan 3 >= NUM_CH) -> oBAD_CMD one pulse, oRP_OE stays 0. Command 0xA0 (bit5 set) -> oBAD_CMD. Byte 0x41 -> no response.
4. Command 0x81 with ch1=0xABCD; after byte 0, ch1 updates to 0x1234 -> second byte still 0xAB. A following 0x81 transfer returns 0x34, 0x12.
5. Command 0x80, then no strobe -> oTIMEOUT pulse 100 cycles after the command strobe, IDLE. Separately, CS raised after byte 0 -> IDLE and oRP_OE=0 within SYNC_STAGES+2 cycles of the pin change.
6. PAR_CHECKSUM_EN defined, ch1=0xABCD, command 0x81 -> bytes 0xCD, 0xAB, 0xE7, then IDLE.
